// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage: access sizes,
// privilege encoding, FSM states and trap cause codes.
package mem_access_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_H = 2'd2,
    PRIV_M = 2'd3
  } priv_mode_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  // The reserved size encoding behaves like a word everywhere.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      default:   is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: byte enables and store-data replication for the
// outgoing request, and shift/swap/extend of returning load data.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  st_offset,
  input  mem_size_t   st_size,
  input  logic        st_big,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  input  logic [1:0]  ld_offset,
  input  mem_size_t   ld_size,
  input  logic        ld_big,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [15:0] st_half;
  logic [31:0] shifted;
  logic [15:0] ld_half;

  always_comb begin
    be        = 4'b1111;
    lane_data = st_data;
    st_half   = st_big ? {st_data[7:0], st_data[15:8]} : st_data[15:0];
    case (st_size)
      SIZE_BYTE: begin
        be        = 4'b0001 << st_offset;
        lane_data = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        be        = 4'b0011 << st_offset;
        lane_data = {2{st_half}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = st_big ? {st_data[7:0], st_data[15:8], st_data[23:16], st_data[31:24]}
                           : st_data;
      end
    endcase
  end

  // Bring the addressed element down to bit 0, then swap and extend.
  always_comb begin
    shifted   = rdata >> {ld_offset, 3'b000};
    ld_half   = ld_big ? {shifted[7:0], shifted[15:8]} : shifted[15:0];
    load_data = shifted;
    case (ld_size)
      SIZE_BYTE: load_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = ld_unsigned ? {16'b0, ld_half}
                                         : {{16{ld_half[15]}}, ld_half};
      default:   load_data = ld_big ? {shifted[7:0], shifted[15:8], shifted[23:16], shifted[31:24]}
                                    : shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one bus transaction per load/store,
// stalls upstream while it is outstanding and reports alignment/fault traps.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble_i,
  input  logic        squash_i,
  input  logic [31:0] pc_i,
  input  logic [1:0]  mem_priv_i,
  input  logic        endianness_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  output logic [1:0]  bus_priv_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_val_o
);

  mem_state_t          state, state_next;
  logic [TIMEOUT_W-1:0] timer;
  mem_size_t           size_in, size_q;
  logic                access, misaligned, start, timed_out, leave_req, fault;
  logic [31:0]         pc_q, addr_q, load_data_q;
  logic                unsigned_q, big_q, fault_q, load_done_q;
  logic [3:0]          cause_q;
  logic [3:0]          align_be;
  logic [31:0]         align_wdata, align_load;

  assign size_in    = mem_size_t'(mem_size_i);
  assign access     = mem_en_i & ~bubble_i & ~squash_i;
  assign misaligned = is_misaligned(size_in, addr_i[1:0]);
  assign start      = access & ~misaligned;
  assign timed_out  = (timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign leave_req  = bus_ack_i | bus_err_i | timed_out;
  // Error beats a simultaneous ack; a timeout only counts when no ack arrived.
  assign fault      = bus_err_i | ~bus_ack_i;
  assign load_data_o = load_data_q;

  mem_align u_align (
    .st_offset   (addr_i[1:0]),
    .st_size     (size_in),
    .st_big      (endianness_i),
    .st_data     (wdata_i),
    .be          (align_be),
    .lane_data   (align_wdata),
    .ld_offset   (addr_q[1:0]),
    .ld_size     (size_q),
    .ld_big      (big_q),
    .ld_unsigned (unsigned_q),
    .rdata       (bus_rdata_i),
    .load_data   (align_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    trap_o       = 1'b0;
    trap_cause_o = cause_q;
    trap_pc_o    = pc_q;
    trap_val_o   = addr_q;
    case (state)
      ST_IDLE: begin
        if (access && misaligned) begin
          trap_o       = 1'b1;
          trap_cause_o = mem_wr_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
          trap_pc_o    = pc_i;
          trap_val_o   = addr_i;
        end else if (start) begin
          stall_o    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (leave_req) state_next = ST_RESP;
      end
      ST_RESP: begin
        load_valid_o = load_done_q & ~squash_i;
        trap_o       = fault_q & ~squash_i;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latches, timeout counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      bus_priv_o  <= '0;
      timer       <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      size_q      <= SIZE_BYTE;
      unsigned_q  <= 1'b0;
      big_q       <= 1'b0;
      fault_q     <= 1'b0;
      load_done_q <= 1'b0;
      cause_q     <= '0;
      load_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_wr_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= align_be;
            bus_wdata_o <= align_wdata;
            bus_priv_o  <= mem_priv_i;
            timer       <= '0;
            pc_q        <= pc_i;
            addr_q      <= addr_i;
            size_q      <= size_in;
            unsigned_q  <= mem_unsigned_i;
            big_q       <= endianness_i;
          end
        end
        ST_REQ: begin
          if (leave_req) begin
            bus_req_o   <= 1'b0;
            timer       <= '0;
            fault_q     <= fault;
            load_done_q <= ~fault & ~bus_we_o;
            if (fault) cause_q <= bus_we_o ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            else if (!bus_we_o) load_data_q <= align_load;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        ST_RESP: begin
          fault_q     <= 1'b0;
          load_done_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, lane placement, alignment
// traps, bus faults, timeout and reset in the middle of a request.
module tb_mem_access;

  logic        clk, rst_n;
  logic        bubble_i, squash_i, endianness_i;
  logic [31:0] pc_i, addr_i, wdata_i;
  logic [1:0]  mem_priv_i, mem_size_i;
  logic        mem_en_i, mem_wr_i, mem_unsigned_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [1:0]  bus_priv_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o, load_valid_o, trap_o;
  logic [31:0] load_data_o, trap_pc_o, trap_val_o;
  logic [3:0]  trap_cause_o;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent transfer.
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr, obs_data, obs_val, obs_pc;
  logic        obs_we, obs_valid, obs_trap, obs_resp_stall, obs_hung;
  logic [3:0]  obs_cause;
  int          obs_stall, obs_req;

  mem_access #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bubble_i(bubble_i), .squash_i(squash_i),
    .pc_i(pc_i), .mem_priv_i(mem_priv_i), .endianness_i(endianness_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_priv_o(bus_priv_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_pc_o(trap_pc_o),
    .trap_val_o(trap_val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_access(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                              input logic [1:0] size, input logic uns, input logic big);
    mem_en_i       = 1'b1;
    addr_i         = addr;
    wdata_i        = data;
    mem_wr_i       = wr;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    endianness_i   = big;
    pc_i           = 32'h8000_0000 + addr;
    mem_priv_i     = 2'd3;
  endtask

  // ack_at / err_at name the REQ cycle (1-based) carrying that response; 0 = never.
  task automatic do_transfer(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                             input logic [1:0] size, input logic uns, input logic big,
                             input logic [31:0] rdata, input int ack_at, input int err_at,
                             input logic resp_squash);
    drive_access(addr, data, wr, size, uns, big);
    bus_rdata_i = rdata;
    obs_stall = 0;
    obs_req   = 0;
    obs_hung  = 1'b1;
    @(negedge clk);
    if (stall_o) obs_stall++;
    next_cycle();
    mem_en_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      bus_ack_i = (c == ack_at);
      bus_err_i = (c == err_at);
      if (c >= 2) squash_i = resp_squash;
      @(negedge clk);
      if (c == 1) begin
        obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_addr = bus_addr_o; obs_we = bus_we_o;
      end
      if (!bus_req_o) begin
        obs_hung = 1'b0;
        break;
      end
      obs_req++;
      if (stall_o) obs_stall++;
      next_cycle();
    end
    obs_valid = load_valid_o; obs_data = load_data_o; obs_trap = trap_o;
    obs_cause = trap_cause_o; obs_val = trap_val_o; obs_pc = trap_pc_o;
    obs_resp_stall = stall_o;
    next_cycle();
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    squash_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bubble_i = 1'b0; squash_i = 1'b0; mem_en_i = 1'b0; mem_wr_i = 1'b0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    drive_access(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    mem_en_i = 1'b0;
    #12;
    checks++; if ({bus_req_o, bus_we_o, stall_o, load_valid_o, trap_o} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 00000", {bus_req_o, bus_we_o, stall_o, load_valid_o, trap_o}); end
    checks++; if ({bus_addr_o, bus_be_o, bus_wdata_o, bus_priv_o} !== 70'b0) begin errors++; $display("[TB] FAIL reset_bus: got %h want 0", {bus_addr_o, bus_be_o, bus_wdata_o, bus_priv_o}); end
    checks++; if ({load_data_o, trap_cause_o, trap_pc_o, trap_val_o} !== 100'b0) begin errors++; $display("[TB] FAIL reset_trap: got %h want 0", {load_data_o, trap_cause_o, trap_pc_o, trap_val_o}); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_word();
    do_transfer(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 1, 0, 1'b0);
    checks++; if (obs_hung !== 1'b0) begin errors++; $display("[TB] FAIL lw_done: got hung=%b want 0", obs_hung); end
    checks++; if (obs_stall !== 2) begin errors++; $display("[TB] FAIL lw_stall_cycles: got %0d want 2", obs_stall); end
    checks++; if (obs_resp_stall !== 1'b0) begin errors++; $display("[TB] FAIL lw_resp_stall: got %b want 0", obs_resp_stall); end
    checks++; if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin errors++; $display("[TB] FAIL lw_bus: got %h/%b/%b want 00000100/1111/0", obs_addr, obs_be, obs_we); end
    checks++; if (obs_valid !== 1'b1 || obs_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data: got %b/%h want 1/deadbeef", obs_valid, obs_data); end
    @(negedge clk);
    checks++; if (load_valid_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lw_after: got valid=%b stall=%b want 0/0", load_valid_o, stall_o); end
    next_cycle();
  endtask

  task automatic test_store_lanes();
    do_transfer(32'h203, 32'h000000A5, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 1, 0, 1'b0);
    checks++; if (obs_be !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL sb_lanes: got %b/%h want 1000/a5a5a5a5", obs_be, obs_wdata); end
    checks++; if (obs_addr !== 32'h200 || obs_we !== 1'b1) begin errors++; $display("[TB] FAIL sb_addr: got %h/%b want 00000200/1", obs_addr, obs_we); end
    checks++; if (obs_valid !== 1'b0 || obs_trap !== 1'b0) begin errors++; $display("[TB] FAIL sb_resp: got %b/%b want 0/0", obs_valid, obs_trap); end
    do_transfer(32'h102, 32'h00001234, 1'b1, 2'd1, 1'b0, 1'b1, 32'h0, 1, 0, 1'b0);
    checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h34123412) begin errors++; $display("[TB] FAIL sh_big_lanes: got %b/%h want 1100/34123412", obs_be, obs_wdata); end
    do_transfer(32'h400, 32'h11223344, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0, 1, 0, 1'b0);
    checks++; if (obs_be !== 4'hF || obs_wdata !== 32'h44332211) begin errors++; $display("[TB] FAIL sw_big_lanes: got %b/%h want 1111/44332211", obs_be, obs_wdata); end
  endtask

  task automatic test_load_extend();
    do_transfer(32'h302, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h80010000, 1, 0, 1'b0);
    checks++; if (obs_data !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL lh_signed: got %h want ffff8001", obs_data); end
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL lh_be: got %b want 1100", obs_be); end
    do_transfer(32'h302, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h80010000, 1, 0, 1'b0);
    checks++; if (obs_data !== 32'h00008001) begin errors++; $display("[TB] FAIL lhu: got %h want 00008001", obs_data); end
    do_transfer(32'h302, 32'h0, 1'b0, 2'd1, 1'b0, 1'b1, 32'h80010000, 1, 0, 1'b0);
    checks++; if (obs_data !== 32'h00000180) begin errors++; $display("[TB] FAIL lh_big: got %h want 00000180", obs_data); end
    do_transfer(32'h101, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00008000, 1, 0, 1'b0);
    checks++; if (obs_data !== 32'hFFFFFF80 || obs_be !== 4'b0010) begin errors++; $display("[TB] FAIL lb_signed: got %h/%b want ffffff80/0010", obs_data, obs_be); end
  endtask

  task automatic test_misaligned();
    drive_access(32'h101, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_nostall: got req=%b stall=%b want 0/0", bus_req_o, stall_o); end
    checks++; if (trap_o !== 1'b1 || trap_cause_o !== 4'd4 || trap_val_o !== 32'h101 || trap_pc_o !== 32'h80000101) begin errors++; $display("[TB] FAIL lw_mis_trap: got %b/%0d/%h/%h want 1/4/00000101/80000101", trap_o, trap_cause_o, trap_val_o, trap_pc_o); end
    next_cycle();
    drive_access(32'h301, 32'h0, 1'b1, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (trap_o !== 1'b1 || trap_cause_o !== 4'd6 || trap_val_o !== 32'h301) begin errors++; $display("[TB] FAIL sh_mis_trap: got %b/%0d/%h want 1/6/00000301", trap_o, trap_cause_o, trap_val_o); end
    next_cycle();
    mem_en_i = 1'b0;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0 || trap_o !== 1'b0) begin errors++; $display("[TB] FAIL mis_after: got req=%b trap=%b want 0/0", bus_req_o, trap_o); end
    next_cycle();
  endtask

  task automatic test_faults();
    do_transfer(32'h600, 32'h55, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_req !== 4) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d want 4", obs_req); end
    checks++; if (obs_trap !== 1'b1 || obs_cause !== 4'd7 || obs_val !== 32'h600 || obs_pc !== 32'h80000600) begin errors++; $display("[TB] FAIL timeout_trap: got %b/%0d/%h/%h want 1/7/00000600/80000600", obs_trap, obs_cause, obs_val, obs_pc); end
    do_transfer(32'h700, 32'h55, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 2, 2, 1'b0);
    checks++; if (obs_req !== 2 || obs_trap !== 1'b1 || obs_cause !== 4'd7) begin errors++; $display("[TB] FAIL err_wins: got req=%0d trap=%b cause=%0d want 2/1/7", obs_req, obs_trap, obs_cause); end
    do_transfer(32'h704, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h12345678, 0, 1, 1'b0);
    checks++; if (obs_trap !== 1'b1 || obs_cause !== 4'd5 || obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_fault: got trap=%b cause=%0d valid=%b want 1/5/0", obs_trap, obs_cause, obs_valid); end
  endtask

  task automatic test_squash_resp();
    do_transfer(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'hCAFEF00D, 1, 0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL squash_load_valid: got %b want 0", obs_valid); end
    do_transfer(32'h800, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 0, 1, 1'b1);
    checks++; if (obs_trap !== 1'b0) begin errors++; $display("[TB] FAIL squash_trap: got %b want 0", obs_trap); end
  endtask

  task automatic test_reset_mid_req();
    drive_access(32'h400, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    next_cycle();
    mem_en_i = 1'b0;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_req: got %b want 1", bus_req_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_drop: got req=%b stall=%b want 0/0", bus_req_o, stall_o); end
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle: got req=%b stall=%b want 0/0", bus_req_o, stall_o); end
    next_cycle();
    do_transfer(32'h500, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h12345678, 1, 0, 1'b0);
    checks++; if (obs_valid !== 1'b1 || obs_data !== 32'h12345678 || obs_addr !== 32'h500) begin errors++; $display("[TB] FAIL rst_next_lw: got %b/%h/%h want 1/12345678/00000500", obs_valid, obs_data, obs_addr); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_lanes();
    test_load_extend();
    test_misaligned();
    test_faults();
    test_squash_resp();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Turns the registered ALU result into a data-bus transaction: address, byte enables, store-data lane placement, and load extraction with sign/zero extension.
- Stalls the pipeline while a transaction is outstanding.
- Reports misaligned-access and access-fault traps.
- Non-memory instructions pass through with no added latency.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without ack/err before an access fault is raised.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bubble_i  in  1  EX/MEM slot holds no valid instruction.
- squash_i  in  1  flush current slot; blocks new bus starts.
- pc_i  in  32  PC of the slot (forwarded for trap reporting).
- mem_priv_i  in  2  rv32::priv_mode_t effective privilege for the access.
- endianness_i  in  1  0 = little, 1 = big.
- addr_i  in  32  effective address (EX/MEM alu_result).
- wdata_i  in  32  store data (EX/MEM alt_data).
- mem_en_i  in  1  slot is a load or store.
- mem_wr_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  rv32::mem_size_t: 0 byte, 1 half, 2 word (3 reserved, treated as word).
- mem_unsigned_i  in  1  load zero-extends.
- bus_req_o  out  1  request valid.
- bus_we_o  out  1  write.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-placed store data.
- bus_priv_o  out  2  privilege of the access.
- bus_ack_i  in  1  transaction complete.
- bus_err_i  in  1  transaction failed.
- bus_rdata_i  in  32  read data, valid with ack.
- stall_o  out  1  hold all upstream stages.
- load_data_o  out  32  extended load result.
- load_valid_o  out  1  load_data_o valid this cycle.
- trap_o  out  1  exception for this slot.
- trap_cause_o  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault.
- trap_pc_o  out  32  PC of the trapping instruction.
- trap_val_o  out  32  faulting address.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE, timeout counter 0.
  - bus_req_o, bus_we_o, stall_o, load_valid_o, trap_o = 0.
  - bus_addr_o, bus_be_o, bus_wdata_o, bus_priv_o, load_data_o, trap_cause_o, trap_pc_o, trap_val_o = 0.
  - Reset mid-transaction drops bus_req_o immediately. The bus must tolerate an abandoned request.
- access = mem_en_i & !bubble_i & !squash_i.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM states IDLE, REQ, RESP (rv32::mem_state_t):
  - IDLE, access & !misaligned:
    - Latch bus_addr/be/wdata/we/priv and pc/addr/size/unsigned/endianness.
    - Next state REQ. stall_o=1 combinationally this cycle.
  - IDLE, access & misaligned:
    - No bus request, no stall.
    - trap_o=1 combinationally with cause 4 or 6, trap_pc_o=pc_i, trap_val_o=addr_i.
  - IDLE, otherwise: pass-through with stall_o=0, load_valid_o=0, trap_o=0.
  - REQ:
    - bus_req_o=1 (registered), stall_o=1, counter increments each cycle.
    - On bus_ack_i: capture extracted data, go to RESP.
    - On bus_err_i, or counter==TIMEOUT_CYCLES-1 without ack: go to RESP with fault (cause 5 or 7, trap_val = latched addr).
    - ack and err in the same cycle: err wins.
    - Leaving REQ: bus_req_o=0 and counter cleared.
  - RESP (one cycle):
    - stall_o=0; load_valid_o=1 for an ack'd load; trap_o=1 for a fault; then IDLE.
    - If squash_i=1 in RESP, load_valid_o and trap_o are forced 0.
- Minimum access latency: 3 cycles (IDLE, REQ, RESP), with ack in the first REQ cycle.
- Squash during REQ does not cancel the bus transaction; stores are never withdrawn.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data:
  - The element (byte-swapped when endianness=1 and size>byte) is replicated across lanes: byte {4{b}}, half {2{h}}, word unchanged.
- Load extraction:
  - rdata >> (8*addr[1:0]), truncate to size, byte-swap when big-endian, then sign- or zero-extend to 32 bits.

Decomposition:
- Shared rv32 package gets mem_size_t, mem_state_t, and localparams for the four trap cause codes.
- One combinational sub-module, mem_align, holds be/wdata generation and load extraction/extension. The parent holds the FSM, timeout counter and latches.

Test Plan:
- LW addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> stall high for 2 cycles, RESP load_data_o=0xDEADBEEF, load_valid_o=1.
- SB addr 0x203, wdata 0x000000A5 -> bus_be_o=4'b1000, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x200, bus_we_o=1.
- LH addr 0x302, rdata 0x80010000: signed -> 0xFFFF8001; unsigned -> 0x00008001; big-endian signed -> 0x00000180.
- LW addr 0x101 -> no bus_req_o, no stall, trap_o=1, cause 4, trap_val_o=0x101.
- SW, bus never acks, TIMEOUT_CYCLES=4 -> bus_req_o high 4 cycles, then RESP trap_o=1, cause 7. Separately: bus_err_i on cycle 2 with ack -> cause 7.
- rst_n low during REQ -> bus_req_o and stall_o drop immediately, state IDLE; next LW completes normally.
